// File: rtl/cube_pkg.sv
// ---------------------------------------------------------------------------
// cube_pkg
//   Shared definitions for the cube scramble logic: face codes, turn
//   directions, the move record and a helper that picks the substitute
//   face when the random source keeps producing unusable draws.
// ---------------------------------------------------------------------------
package cube_pkg;

    localparam int NUM_FACES = 6;

    typedef enum logic [2:0] {
        FACE_U = 3'd0,
        FACE_D = 3'd1,
        FACE_L = 3'd2,
        FACE_R = 3'd3,
        FACE_F = 3'd4,
        FACE_B = 3'd5
    } face_e;

    typedef enum logic {
        DIR_CW  = 1'b0,
        DIR_CCW = 1'b1
    } dir_e;

    typedef struct packed {
        face_e face;
        dir_e  dir;
    } move_t;

    // Substitute face: the one after the previous face, wrapping B -> U.
    // With no previous face in this scramble, U is used.
    function automatic face_e next_face(input face_e prev, input logic prev_valid);
        if (!prev_valid || prev == FACE_B) begin
            return FACE_U;
        end
        return face_e'(prev + 3'd1);
    endfunction

endpackage

// File: rtl/move_decoder.sv
// ---------------------------------------------------------------------------
// move_decoder
//   Turns a 4-bit random value into a candidate move and flags it when it
//   cannot be used.
//
//   i_v           in  4  random value {hi, lo}, 0..15
//   i_prev_face   in  3  face of the previously accepted move
//   i_prev_valid  in  1  i_prev_face holds a face from this scramble
//   o_face        out 3  candidate face (i_v >> 1)
//   o_dir         out 1  candidate direction (i_v[0])
//   o_reject      out 1  value out of range or face repeats the previous one
// ---------------------------------------------------------------------------
module move_decoder
    import cube_pkg::*;
(
    input  logic [3:0] i_v,
    input  logic [2:0] i_prev_face,
    input  logic       i_prev_valid,
    output logic [2:0] o_face,
    output logic       o_dir,
    output logic       o_reject
);

    logic w_out_of_range;
    logic w_repeat;

    assign o_face = i_v[3:1];
    assign o_dir  = i_v[0];

    // Only the first 2*NUM_FACES codes map onto a face/direction pair;
    // the rest are discarded rather than folded, to keep the faces uniform.
    assign w_out_of_range = (i_v >= 4'(2 * NUM_FACES));
    assign w_repeat       = i_prev_valid && (o_face == i_prev_face);
    assign o_reject       = w_out_of_range || w_repeat;

endmodule

// File: rtl/scramble_sequencer.sv
// ---------------------------------------------------------------------------
// scramble_sequencer
//   Generates a scramble of SCRAMBLE_LEN cube moves. Each move is built from
//   two 2-bit draws of an external random generator (high half, then low
//   half). Unusable draws are retried up to MAX_RETRY times before a
//   deterministic substitute move is used. Moves are offered with a
//   valid/ready handshake.
//
//   Parameters: SCRAMBLE_LEN (1..31), RNG_LAT (>= 1), MAX_RETRY.
//
//   clk         in  1  rising-edge clock
//   reset       in  1  asynchronous reset, active low
//   start       in  1  begin a scramble (only looked at while idle)
//   rand_in     in  4  generator output, bits [1:0] used
//   rand_step   out 1  one-cycle request for a new random value
//   move_valid  out 1  move_face/move_dir/move_idx carry a move
//   move_ready  in  1  downstream accepts the move
//   move_face   out 3  face code U,D,L,R,F,B = 0..5
//   move_dir    out 1  0 clockwise, 1 counter-clockwise
//   move_idx    out 5  position of the move within the scramble
//   busy        out 1  scramble in progress
//   done        out 1  one-cycle pulse after the last move is accepted
// ---------------------------------------------------------------------------
module scramble_sequencer
    import cube_pkg::*;
#(
    parameter int SCRAMBLE_LEN = 20,
    parameter int RNG_LAT      = 2,
    parameter int MAX_RETRY    = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] rand_in,
    output logic       rand_step,
    output logic       move_valid,
    input  logic       move_ready,
    output logic [2:0] move_face,
    output logic       move_dir,
    output logic [4:0] move_idx,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_STEP_HI = 3'd1;
    localparam logic [2:0] S_WAIT_HI = 3'd2;
    localparam logic [2:0] S_STEP_LO = 3'd3;
    localparam logic [2:0] S_WAIT_LO = 3'd4;
    localparam logic [2:0] S_CHECK   = 3'd5;
    localparam logic [2:0] S_OFFER   = 3'd6;

    localparam int WAIT_W  = (RNG_LAT > 1) ? $clog2(RNG_LAT) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [WAIT_W-1:0]  LAT_LAST   = WAIT_W'(RNG_LAT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);
    localparam logic [4:0]         LAST_IDX   = 5'(SCRAMBLE_LEN - 1);

    logic [2:0]         r_state;
    logic [WAIT_W-1:0]  r_wait;
    logic [1:0]         r_hi;
    logic [1:0]         r_lo;
    logic [RETRY_W-1:0] r_retry;
    face_e              r_prev_face;
    logic               r_prev_valid;
    move_t              r_move;
    logic [4:0]         r_idx;
    logic               r_done;

    logic [2:0] w_face;
    logic       w_dir;
    logic       w_reject;
    face_e      w_fallback;

    // The generator drives a full nibble; only the low two bits carry
    // entropy for this block.
    logic w_unused_rand_hi;
    assign w_unused_rand_hi = ^rand_in[3:2];

    move_decoder u_move_decoder (
        .i_v          ({r_hi, r_lo}),
        .i_prev_face  (r_prev_face),
        .i_prev_valid (r_prev_valid),
        .o_face       (w_face),
        .o_dir        (w_dir),
        .o_reject     (w_reject)
    );

    assign w_fallback = next_face(r_prev_face, r_prev_valid);

    // NOTE: every register below is assigned with <= so all of them update
    // together from the values present before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_wait       <= '0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_retry      <= '0;
            r_prev_face  <= FACE_U;
            r_prev_valid <= 1'b0;
            r_move       <= '0;
            r_idx        <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx        <= '0;
                        r_retry      <= '0;
                        r_prev_valid <= 1'b0;
                        r_state      <= S_STEP_HI;
                    end
                end
                S_STEP_HI: begin
                    r_wait  <= '0;
                    r_state <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (r_wait == LAT_LAST) begin
                        r_hi    <= rand_in[1:0];
                        r_state <= S_STEP_LO;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_STEP_LO: begin
                    r_wait  <= '0;
                    r_state <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (r_wait == LAT_LAST) begin
                        r_lo    <= rand_in[1:0];
                        r_state <= S_CHECK;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (!w_reject) begin
                        r_move  <= '{face: face_e'(w_face), dir: dir_e'(w_dir)};
                        r_state <= S_OFFER;
                    end else if (r_retry == RETRY_LAST) begin
                        // This rejection would exceed the retry budget:
                        // stop drawing and use the substitute move.
                        r_move  <= '{face: w_fallback, dir: DIR_CW};
                        r_state <= S_OFFER;
                    end else begin
                        r_retry <= r_retry + 1'b1;
                        r_state <= S_STEP_HI;
                    end
                end
                S_OFFER: begin
                    if (move_ready) begin
                        r_prev_face  <= r_move.face;
                        r_prev_valid <= 1'b1;
                        r_retry      <= '0;
                        if (r_idx == LAST_IDX) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 5'd1;
                            r_state <= S_STEP_HI;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rand_step  = (r_state == S_STEP_HI) || (r_state == S_STEP_LO);
    assign move_valid = (r_state == S_OFFER);
    assign busy       = (r_state != S_IDLE);
    assign move_face  = r_move.face;
    assign move_dir   = r_move.dir;
    assign move_idx   = r_idx;
    assign done       = r_done;

endmodule

// File: tb/tb_scramble_sequencer.sv
// ---------------------------------------------------------------------------
// tb_scramble_sequencer
//   Directed table of moves with hand-derived results, hand-written
//   sequences for stalls and mid-scramble reset, then random draws and
//   random handshakes checked against a draw-list reference model.
// ---------------------------------------------------------------------------
module tb_scramble_sequencer;

    localparam int LEN       = 3;
    localparam int RNG_LAT   = 2;
    localparam int MAX_RETRY = 15;
    localparam int NFACES    = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] rand_in;
    logic       rand_step;
    logic       move_valid;
    logic       move_ready;
    logic [2:0] move_face;
    logic       move_dir;
    logic [4:0] move_idx;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    bit bias_mode = 1'b0;

    logic [1:0] q_stub[$];  // scripted draw halves, consumed first
    logic [1:0] q_log[$];   // every half actually presented, for the model

    typedef struct packed {
        logic [4:0]       n_pairs;
        logic [15:0][3:0] v;
        logic [2:0]       face;
        logic             dir;
    } vec_t;

    vec_t tbl [6];

    scramble_sequencer #(
        .SCRAMBLE_LEN (LEN),
        .RNG_LAT      (RNG_LAT),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rand_in    (rand_in),
        .rand_step  (rand_step),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .move_face  (move_face),
        .move_dir   (move_dir),
        .move_idx   (move_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [1:0] rnd_half();
        if (bias_mode && $urandom_range(0, 7) != 0) return 2'd3;
        return 2'($urandom_range(0, 3));
    endfunction

    // Generator stub: a rand_step pulse seen at an edge makes the next value
    // appear RNG_LAT cycles after the pulse cycle; before that rand_in is junk.
    initial begin : rng_stub
        logic [1:0] pend;
        int         cnt;
        bit         step_seen;
        bit         active;
        rand_in = '0;
        active  = 1'b0;
        cnt     = 0;
        pend    = '0;
        forever begin
            @(posedge clk);
            step_seen = rand_step;
            #1;
            if (!reset) begin
                active = 1'b0;
                q_log.delete();
                q_stub.delete();
            end else if (step_seen) begin
                if (q_stub.size() > 0) pend = q_stub.pop_front();
                else pend = rnd_half();
                q_log.push_back(pend);
                cnt = RNG_LAT - 1;
                if (cnt == 0) rand_in = {2'($urandom), pend};
                else rand_in = 4'($urandom);
                active = (cnt != 0);
            end else if (active) begin
                cnt--;
                if (cnt == 0) begin
                    rand_in = {2'($urandom), pend};
                    active  = 1'b0;
                end
            end
        end
    end

    initial begin : done_monitor
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
        end
    end

    // Reference model: walk the logged draw pairs of one move and apply the
    // acceptance rules; ok=0 if the log does not hold exactly that many draws.
    task automatic model_move(input int prev, output int face, output int dir, output bit ok);
        int rejects, hi, lo, v;
        bit fin;
        rejects = 0; fin = 1'b0; ok = 1'b1; face = 0; dir = 0;
        while (!fin) begin
            if (q_log.size() < 2) begin
                ok  = 1'b0;
                fin = 1'b1;
            end else begin
                hi = int'(q_log.pop_front());
                lo = int'(q_log.pop_front());
                v  = hi * 4 + lo;
                if (v < 2 * NFACES && (v / 2) != prev) begin
                    face = v / 2;
                    dir  = v % 2;
                    fin  = 1'b1;
                end else begin
                    rejects++;
                    if (rejects > MAX_RETRY) begin
                        face = (prev < 0) ? 0 : (prev + 1) % NFACES;
                        dir  = 0;
                        fin  = 1'b1;
                    end
                end
            end
        end
        if (q_log.size() != 0) ok = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where move_valid is seen.
    // lat is 0-based from the calling cycle, steps counts rand_step cycles.
    task automatic wait_offer(output int steps, output int lat, output bit ok);
        steps = 0; lat = -1; ok = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (move_valid) begin
                lat = n;
                ok  = 1'b1;
                break;
            end
            if (rand_step) steps++;
            @(negedge clk);
        end
    endtask

    task automatic run_scramble(input int first, input int slow_row, input bit eager);
        int steps, lat, r, bad;
        bit ok;
        logic [8:0] held;
        for (int i = first; i < first + LEN; i++) begin
            for (int k = 0; k < int'(tbl[i].n_pairs); k++) begin
                q_stub.push_back(tbl[i].v[k][3:2]);
                q_stub.push_back(tbl[i].v[k][1:0]);
            end
        end
        start      = 1'b1;
        move_ready = eager;
        @(negedge clk);
        start = 1'b0;
        for (int m = 0; m < LEN; m++) begin
            r = first + m;
            wait_offer(steps, lat, ok);
            if (!ok) begin
                check($sformatf("offer_timeout_row%0d", r), 0, 1);
                move_ready = 1'b0;
                return;
            end
            check($sformatf("face_row%0d", r), 32'(move_face), 32'(tbl[r].face));
            check($sformatf("dir_row%0d", r), 32'(move_dir), 32'(tbl[r].dir));
            check($sformatf("idx_row%0d", r), 32'(move_idx), 32'(m));
            check($sformatf("steps_row%0d", r), 32'(steps), 32'(2 * int'(tbl[r].n_pairs)));
            if (tbl[r].n_pairs == 5'd1)
                check($sformatf("latency_row%0d", r), 32'(lat + 1), 32'(2 * (RNG_LAT + 1) + 2));
            if (r == slow_row) begin
                held = {move_face, move_dir, move_idx};
                bad  = 0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    if (!move_valid || rand_step || {move_face, move_dir, move_idx} !== held) bad++;
                end
                check($sformatf("stall_stable_row%0d", r), 32'(bad), 0);
            end
            move_ready = 1'b1;
            @(negedge clk);
            check($sformatf("valid_drop_row%0d", r), 32'(move_valid), 0);
            move_ready = eager;
            if (m == LEN - 1) begin
                check($sformatf("done_pulse_row%0d", r), 32'(done), 1);
                check($sformatf("idle_after_last_row%0d", r), 32'(busy), 0);
                move_ready = 1'b0;
                @(negedge clk);
                check($sformatf("done_single_row%0d", r), 32'(done), 0);
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, 32'({move_face, move_dir, move_idx, busy, done, rand_step, move_valid}), 0);
    endtask

    initial begin : main
        int steps, lat, d0;
        bit ok;
        int prev, ef, ed, exp_idx, n_offers, wd;
        bit in_run, offered, exp_done, hs_last;

        for (int i = 0; i < 6; i++) tbl[i] = '0;
        tbl[0].n_pairs = 5'd1; tbl[0].v[0] = 4'd9;  tbl[0].face = 3'd4; tbl[0].dir = 1'b1;
        tbl[1].n_pairs = 5'd2; tbl[1].v[0] = 4'd13; tbl[1].v[1] = 4'd0;
        tbl[1].face = 3'd0; tbl[1].dir = 1'b0;
        tbl[2].n_pairs = 5'd1; tbl[2].v[0] = 4'd7;  tbl[2].face = 3'd3; tbl[2].dir = 1'b1;
        tbl[3].n_pairs = 5'd1; tbl[3].v[0] = 4'd7;  tbl[3].face = 3'd3; tbl[3].dir = 1'b1;
        tbl[4].n_pairs = 5'd2; tbl[4].v[0] = 4'd6;  tbl[4].v[1] = 4'd10;
        tbl[4].face = 3'd5; tbl[4].dir = 1'b0;
        tbl[5].n_pairs = 5'd16;
        for (int k = 0; k < 16; k++) tbl[5].v[k] = 4'd15;
        tbl[5].face = 3'd0; tbl[5].dir = 1'b0;

        // Reset state, with start and ready wiggling underneath it.
        reset = 1'b0; start = 1'b0; move_ready = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; move_ready = 1'b1;
        @(negedge clk);
        check("rst_face", 32'(move_face), 0);
        check("rst_dir", 32'(move_dir), 0);
        check("rst_idx", 32'(move_idx), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rand_step", 32'(rand_step), 0);
        check("rst_valid", 32'(move_valid), 0);
        start = 1'b0; move_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 32'(busy), 0);

        // Scramble A: plain move, rejection of v=13, stall on move 1.
        run_scramble(0, 1, 1'b0);
        check("done_count_a", 32'(done_cnt), 1);
        // Scramble B: repeat-face rejection and fallback, ready held high.
        run_scramble(3, -1, 1'b1);
        check("done_count_b", 32'(done_cnt), 2);

        // Abort during move 1, then restart from index 0.
        q_stub.push_back(2'd2); q_stub.push_back(2'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_offer(steps, lat, ok);
        check("abort_first_offer", 32'(ok), 1);
        move_ready = 1'b1;
        @(negedge clk);
        move_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_abort", 32'(busy), 1);
        d0 = done_cnt;
        reset = 1'b0; start = 1'b1;
        #1;
        check_all_zero("abort_immediate");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_all_zero($sformatf("abort_hold%0d", c));
        end
        start = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("post_abort_idle%0d", c), 32'(busy), 0);
        end
        check("no_done_after_abort", 32'(done_cnt), 32'(d0));
        q_stub.push_back(2'd2); q_stub.push_back(2'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_offer(steps, lat, ok);
        check("restart_offer", 32'(ok), 1);
        check("restart_idx", 32'(move_idx), 0);
        check("restart_face", 32'(move_face), 4);
        check("restart_dir", 32'(move_dir), 1);
        check("restart_latency", 32'(lat + 1), 32'(2 * (RNG_LAT + 1) + 2));
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Random draws, random ready, random start against the model.
        q_log.delete();
        in_run = 1'b0; offered = 1'b0; exp_done = 1'b0;
        prev = -1; ef = 0; ed = 0; exp_idx = 0; n_offers = 0; wd = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc == 2000) bias_mode = 1'b1;
            check("rand_busy", 32'(busy), 32'(in_run));
            check("rand_done", 32'(done), 32'(exp_done));
            if (!in_run) check("rand_valid_idle", 32'(move_valid), 0);
            if (in_run && move_valid) begin
                if (!offered) begin
                    model_move(prev, ef, ed, ok);
                    check("rand_draws", 32'(ok), 1);
                    offered = 1'b1;
                    n_offers++;
                end
                check("rand_move", 32'({move_face, move_dir, move_idx}),
                      32'({3'(ef), 1'(ed), 5'(exp_idx)}));
            end
            if (in_run && !move_valid) wd++;
            else wd = 0;
            if (wd == 400) check("rand_progress", 0, 1);

            exp_done   = 1'b0;
            move_ready = 1'($urandom_range(0, 1));
            start      = ($urandom_range(0, 5) == 0);
            if (in_run) begin
                if (move_valid && move_ready) begin
                    prev    = ef;
                    offered = 1'b0;
                    hs_last = (exp_idx == LEN - 1);
                    if (hs_last) begin
                        in_run   = 1'b0;
                        exp_done = 1'b1;
                    end else begin
                        exp_idx++;
                    end
                end
            end else if (start) begin
                in_run  = 1'b1;
                exp_idx = 0;
                prev    = -1;
            end
        end
        start = 1'b0; move_ready = 1'b0;
        check("rand_moves_seen", 32'(n_offers > 50), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
